// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-aligned fetch requests under a credit
// limit, buffers in-order responses with their PCs in a small FIFO, and
// handles redirects by flushing the FIFO and discarding stale responses.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0080_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int          PW          = $clog2(DEPTH);
  localparam int          CW          = PW + 1;
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
  localparam logic [CW:0] DEPTH_W     = (CW + 1)'(DEPTH);

  // Architectural state
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  // Buffer storage: one PC and one instruction word per entry
  logic [31:0] fifo_pc_mem   [DEPTH];
  logic [31:0] fifo_data_mem [DEPTH];

  // Event qualifiers
  logic req_hs;
  logic rsp_accept;
  logic rsp_push;
  logic rsp_stale;
  logic pop;
  logic credit_ok;

  // Low redirect bits are forced to zero, so they are intentionally unused
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Handshake qualifiers and credit check; a request is only offered when
  // every in-flight response is guaranteed a free buffer slot
  always_comb begin
    credit_ok     = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_W;
    mem_req_valid = reset_n & ~redirect_valid & credit_ok;
    mem_req_addr  = reset_n ? fetch_pc_q : RESET_PC_AL;
    inst_valid    = reset_n & (count_q != '0);
    inst_data     = fifo_data_mem[rd_ptr_q];
    inst_pc       = fifo_pc_mem[rd_ptr_q];
    req_hs        = mem_req_valid & mem_req_ready;
    // Responses with nothing in flight are spurious and ignored entirely
    rsp_accept    = mem_rsp_valid & (outstanding_q != '0);
    rsp_push      = rsp_accept & ~redirect_valid & (discard_q == '0);
    rsp_stale     = rsp_accept & ~redirect_valid & (discard_q != '0);
    pop           = inst_valid & inst_ready & ~redirect_valid;
  end

  // Next-state computation for PCs, credit counters and FIFO pointers
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_accept);

    if (redirect_valid) begin
      // Flush: everything still in flight after this cycle is stale
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc[31:2], 2'b00};
      discard_d  = outstanding_q - CW'(rsp_accept);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rsp_stale) begin
        discard_d = discard_q - CW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(rsp_push) - CW'(pop);
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC_AL;
      rsp_pc_q      <= RESET_PC_AL;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Buffer write port; contents need no reset since count gates validity
  always_ff @(posedge clk) begin
    if (reset_n && rsp_push) begin
      fifo_pc_mem[wr_ptr_q]   <= rsp_pc_q;
      fifo_data_mem[wr_ptr_q] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written redirect
// sequences, then randomized traffic, all checked against a queue-based model.
module tb_instr_fetch;

  localparam logic [31:0] RPC   = 32'h0080_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  instr_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: in-flight requests tagged stale on redirect, and a
  // queue of buffered {pc, data} entries.
  typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  req_t        inflight[$];
  ent_t        fifo_m[$];
  logic [31:0] m_fetch = RPC;
  logic        m_rv;
  int          cyc = 0;
  int          extra_lat = 0;

  typedef struct {
    logic rst_n; logic rq_rdy; logic rs_vld; logic [31:0] rs_data; logic i_rdy;
    logic e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_ipc; logic [31:0] e_idat;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dw(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic rq_rdy, input logic rs_vld,
                              input logic [31:0] rs_data, input logic i_rdy, input logic e_rv,
                              input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_ipc, input logic [31:0] e_idat);
    vec_t v;
    v.rst_n = rst_n; v.rq_rdy = rq_rdy; v.rs_vld = rs_vld; v.rs_data = rs_data;
    v.i_rdy = i_rdy; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_ipc = e_ipc; v.e_idat = e_idat;
    return v;
  endfunction

  task automatic drv(input logic rst_n, input logic rq_rdy, input logic rs_vld,
                     input logic [31:0] rs_data, input logic rd_vld,
                     input logic [31:0] rd_pc, input logic i_rdy);
    reset_n = rst_n; mem_req_ready = rq_rdy; mem_rsp_valid = rs_vld;
    mem_rsp_data = rs_data; redirect_valid = rd_vld; redirect_pc = rd_pc;
    inst_ready = i_rdy;
  endtask

  // Compare DUT outputs with the model mid-cycle
  task automatic sample();
    logic iv;
    @(negedge clk);
    m_rv = reset_n && !redirect_valid && ((fifo_m.size() + inflight.size()) < DEPTH);
    iv   = reset_n && (fifo_m.size() > 0);
    chk("model_req_valid", {31'b0, mem_req_valid}, {31'b0, m_rv});
    chk("model_req_addr", mem_req_addr, reset_n ? m_fetch : RPC);
    chk("model_inst_valid", {31'b0, inst_valid}, {31'b0, iv});
    if (iv) begin
      chk("model_inst_pc", inst_pc, fifo_m[0].pc);
      chk("model_inst_data", inst_data, fifo_m[0].data);
    end
  endtask

  // Advance the model across the clock edge using the applied inputs
  task automatic advance();
    req_t e;
    bit   rsp;
    @(posedge clk);
    if (!reset_n) begin
      inflight.delete();
      fifo_m.delete();
      m_fetch = RPC;
    end else begin
      rsp = mem_rsp_valid && (inflight.size() > 0);
      if (rsp) e = inflight.pop_front();
      if (redirect_valid) begin
        fifo_m.delete();
        foreach (inflight[k]) inflight[k].stale = 1'b1;
        m_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
        if (inst_ready && fifo_m.size() > 0) void'(fifo_m.pop_front());
        if (rsp && !e.stale) fifo_m.push_back('{e.addr, mem_rsp_data});
        if (m_rv && mem_req_ready) begin
          inflight.push_back('{m_fetch, 1'b0, cyc + 1 + extra_lat});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0);

    // Streaming: 1-cycle responses, core always ready
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, RPC, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 1, i >= 1, (i >= 1) ? dw(i - 1) : 32'h0, 1,
                        1, RPC + 32'(4 * i), i >= 2,
                        (i >= 2) ? RPC + 32'(4 * (i - 2)) : 32'h0,
                        (i >= 2) ? dw(i - 2) : 32'h0));
    // Request stall at 0x00800008 for 3 cycles, then credit limit
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, RPC, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, RPC, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, RPC + 4, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 0, 0, 1, 1, RPC + 8, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, RPC + 8, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, RPC + 12, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, RPC + 16, 0, 0, 0));
    // Backpressure from the core, one pop, then reset with the buffer full
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, RPC, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, RPC, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, dw(0), 0, 1, RPC + 4, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, dw(1), 0, 1, RPC + 8, 1, RPC, dw(0)));
    vecs.push_back(mk(1, 1, 1, dw(2), 0, 1, RPC + 12, 1, RPC, dw(0)));
    vecs.push_back(mk(1, 1, 1, dw(3), 0, 0, RPC + 16, 1, RPC, dw(0)));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, RPC + 16, 1, RPC, dw(0)));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, RPC + 16, 1, RPC, dw(0)));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, RPC + 16, 1, RPC, dw(0)));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, RPC + 16, 1, RPC + 4, dw(1)));
    vecs.push_back(mk(1, 1, 1, dw(4), 0, 0, RPC + 20, 1, RPC + 4, dw(1)));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, RPC + 20, 1, RPC + 4, dw(1)));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, RPC, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, RPC, 0, 0, 0));

    sample(); advance();
    sample(); advance();

    for (int i = 0; i < vecs.size(); i++) begin
      drv(vecs[i].rst_n, vecs[i].rq_rdy, vecs[i].rs_vld, vecs[i].rs_data, 0, 0, vecs[i].i_rdy);
      sample();
      chk($sformatf("vec%0d_req_valid", i), {31'b0, mem_req_valid}, {31'b0, vecs[i].e_rv});
      chk($sformatf("vec%0d_req_addr", i), mem_req_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_iv});
      if (vecs[i].e_iv) begin
        chk($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].e_ipc);
        chk($sformatf("vec%0d_inst_data", i), inst_data, vecs[i].e_idat);
      end
      $display("vec %0d: req_valid=%0b addr=%h inst_valid=%0b inst_pc=%h", i,
               mem_req_valid, mem_req_addr, inst_valid, inst_pc);
      advance();
    end

    // Redirect to 0x00001002 with two requests outstanding
    drv(0, 0, 0, 0, 0, 0, 0); sample(); advance();
    drv(1, 1, 0, 0, 0, 0, 0); sample(); advance();
    drv(1, 1, 0, 0, 0, 0, 0); sample(); advance();
    drv(1, 1, 0, 0, 1, 32'h0000_1002, 0); sample();
    chk("redir_req_blocked", {31'b0, mem_req_valid}, 32'd0);
    advance();
    drv(1, 1, 0, 0, 0, 0, 0); sample();
    chk("redir_next_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("redir_next_addr", mem_req_addr, 32'h0000_1000);
    advance();
    drv(1, 1, 1, 32'hDEAD_0001, 0, 0, 0); sample();
    chk("redir_addr2", mem_req_addr, 32'h0000_1004);
    advance();
    drv(1, 0, 1, 32'hDEAD_0002, 0, 0, 0); sample();
    chk("stale1_dropped", {31'b0, inst_valid}, 32'd0);
    advance();
    drv(1, 0, 1, 32'hA000_1000, 0, 0, 0); sample();
    chk("stale2_dropped", {31'b0, inst_valid}, 32'd0);
    advance();
    drv(1, 1, 1, 32'hB000_1004, 0, 0, 0); sample();
    chk("redir_first_valid", {31'b0, inst_valid}, 32'd1);
    chk("redir_first_pc", inst_pc, 32'h0000_1000);
    chk("redir_first_data", inst_data, 32'hA000_1000);
    $display("seq redirect: first inst_pc=%h data=%h", inst_pc, inst_data);
    advance();
    drv(1, 1, 0, 0, 0, 0, 0); sample(); advance();
    // Redirect coinciding with a response and a pop
    drv(1, 0, 1, 32'hC000_1008, 1, 32'h0000_2000, 1); sample();
    chk("coinc_req_blocked", {31'b0, mem_req_valid}, 32'd0);
    advance();
    drv(1, 0, 1, 32'hDEAD_0003, 0, 0, 0); sample();
    chk("coinc_fifo_empty", {31'b0, inst_valid}, 32'd0);
    chk("coinc_req_addr", mem_req_addr, 32'h0000_2000);
    advance();
    // Spurious response with nothing outstanding must be ignored
    drv(1, 1, 1, 32'hBAD0_0000, 0, 0, 0); sample();
    chk("coinc_stale_dropped", {31'b0, inst_valid}, 32'd0);
    advance();
    drv(1, 0, 1, 32'hE000_2000, 0, 0, 0); sample();
    chk("spurious_ignored", {31'b0, inst_valid}, 32'd0);
    advance();
    drv(1, 0, 0, 0, 0, 0, 0); sample();
    chk("coinc_first_pc", inst_pc, 32'h0000_2000);
    chk("coinc_first_data", inst_data, 32'hE000_2000);
    $display("seq coincident redirect: inst_pc=%h data=%h", inst_pc, inst_data);
    advance();

    // Randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      reset_n        = ($urandom_range(0, 599) != 0);
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      extra_lat      = $urandom_range(0, 3);
      if (inflight.size() > 0)
        mem_rsp_valid = (inflight[0].due <= cyc) && ($urandom_range(0, 3) != 0);
      else
        mem_rsp_valid = ($urandom_range(0, 19) == 0);
      mem_rsp_data   = $urandom;
      sample();
      if (t % 250 == 0)
        $display("rand %0d: req_valid=%0b addr=%h inst_valid=%0b inst_pc=%h", t,
                 mem_req_valid, mem_req_addr, inst_valid, inst_pc);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0080_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, instruction buffer entries; power of 2, >=2.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port mem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port mem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port mem_rsp_valid  input  1  instruction word returned; in order, latency >=1 cycle.
REQ-009 SHALL have port mem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  one-cycle pulse from core on taken branch/jump.
REQ-011 SHALL have port redirect_pc  input  32  new fetch target.
REQ-012 SHALL have port inst_valid  output  1  buffered instruction available to core.
REQ-013 SHALL have port inst_ready  input  1  core consumes instruction.
REQ-014 SHALL have port inst_data  output  32  head instruction word.
REQ-015 SHALL have port inst_pc  output  32  PC of head instruction.

Function
REQ-016 SHALL keep fetch_pc; request handshake = mem_req_valid & mem_req_ready; each handshake sets fetch_pc += 4 (wraps mod 2^32).
REQ-017 SHALL drive mem_req_addr = fetch_pc, with low 2 bits always 0.
REQ-018 SHALL assert mem_req_valid iff buffer count + outstanding < DEPTH and redirect_valid = 0.
REQ-019 SHALL hold mem_req_valid and mem_req_addr stable while mem_req_ready = 0, except on redirect.
REQ-020 SHALL track outstanding: +1 per request handshake, -1 per mem_rsp_valid, net 0 when both occur in one cycle; width clog2(DEPTH)+1.
REQ-021 SHALL keep rsp_pc: PC of next expected non-discarded response; +4 per buffered response.
REQ-022 SHALL push {rsp_pc, mem_rsp_data} into FIFO on mem_rsp_valid when discard = 0.
REQ-023 SHALL drive inst_valid = FIFO non-empty; inst_data/inst_pc = head entry; pop on inst_valid & inst_ready.
REQ-024 SHALL allow push and pop in the same cycle with count unchanged.
REQ-025 SHALL never overflow: credit rule REQ-018 guarantees a free slot for every outstanding response.
REQ-026 SHALL, on redirect_valid: flush FIFO (count 0, any pop that cycle ignored); fetch_pc and rsp_pc <= {redirect_pc[31:2],2'b00}; discard <= outstanding - mem_rsp_valid.
REQ-027 SHALL drop any response arriving in the redirect cycle, unbuffered.
REQ-028 SHALL, while discard > 0, drop each mem_rsp_valid and decrement discard.
REQ-029 SHALL recompute discard per REQ-026 on a new redirect while discard > 0; the latest redirect wins.
REQ-030 SHALL ignore mem_rsp_valid when outstanding = 0; no state change.
REQ-031 SHALL assert mem_req_valid no earlier than the cycle after redirect_valid.

Reset
REQ-032 SHALL, while reset_n = 0 at posedge, set fetch_pc = rsp_pc = RESET_PC and count = outstanding = discard = 0.
REQ-033 SHALL hold mem_req_valid = 0 and inst_valid = 0 during reset; mem_req_addr = RESET_PC.
REQ-034 SHALL ignore redirect_valid, mem_rsp_valid and inst_ready during reset.
REQ-035 SHALL assert mem_req_valid in the first cycle with reset_n = 1.
REQ-036 SHALL discard all in-flight state on reset asserted mid-operation; the memory side resets in the same domain.

Verification
REQ-037 SHALL cover streaming: ready = 1, 1-cycle response, inst_ready = 1 -> addrs 0x00800000, 0x00800004, 0x00800008...; inst_pc matches each word in order.
REQ-038 SHALL cover backpressure: inst_ready = 0, DEPTH = 4 -> exactly 4 requests then mem_req_valid = 0; head inst_pc = 0x00800000 held; one pop -> one new request.
REQ-039 SHALL cover a redirect to 0x00001002 with 2 outstanding -> next addr 0x00001000; 2 stale responses dropped; first inst_pc = 0x00001000.
REQ-040 SHALL cover a redirect coinciding with mem_rsp_valid and inst pop -> that response dropped, FIFO empty next cycle, discard = outstanding - 1.
REQ-041 SHALL cover mem_req_ready = 0 for 3 cycles at addr 0x00800008 -> addr and valid stable; handshake on cycle 4 -> next addr 0x0080000C.
REQ-042 SHALL cover reset mid-run with FIFO full -> next cycle inst_valid = 0, mem_req_valid = 0; after release, first addr = 0x00800000.
